// File: rtl/au_operand_sequencer.sv
// ---------------------------------------------------------------------------
// au_operand_sequencer
//
// Feeds an 8-bit pipelined arithmetic unit from a single valid/ready byte
// stream. The first accepted beat is operand A (with its op select), the
// second is operand B. Both are held on the AU inputs while the sequencer
// waits out the AU pipeline. It then captures the AU output and presents it
// on a valid/ready result port, together with sign/zero flags and a count
// of completed operations.
//
// Parameters
//   AU_LATENCY  clock edges from AU input sampling to a valid au_out
//   CNT_W       width of the completed-operation counter
//
// Ports
//   clk, rst_n           clock (rising edge), async active-low reset
//   flush                synchronous abort back to IDLE
//   in_valid/in_ready    operand stream handshake
//   in_data, in_op       operand beat (A then B), op select (taken with A)
//   au_a, au_b, au_sel   registered operands/select driven to the AU
//   au_out               AU result
//   res_valid/res_ready  result handshake
//   res_data, res_op     captured result and the select that produced it
//   res_neg, res_zero    sign / zero flags of res_data
//   busy                 sequencer not idle
//   op_count             results accepted downstream (wraps)
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | waiting for operand A beat
// GET_B | A and select latched, waiting for operand B beat
// EXEC  | operands stable on AU, counting down the AU pipeline
// HOLD  | result presented, waiting for res_ready
// ---------------------------------------------------------------------------
module au_operand_sequencer #(
    parameter int AU_LATENCY = 1,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_data,
    input  logic [1:0]       in_op,
    output logic [7:0]       au_a,
    output logic [7:0]       au_b,
    output logic [1:0]       au_sel,
    input  logic [7:0]       au_out,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [7:0]       res_data,
    output logic [1:0]       res_op,
    output logic             res_neg,
    output logic             res_zero,
    output logic             busy,
    output logic [CNT_W-1:0] op_count
);

    // The counter must hold AU_LATENCY; at least one bit even for zero latency.
    localparam int LAT_W = (AU_LATENCY < 1) ? 1 : $clog2(AU_LATENCY + 1);
    localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(AU_LATENCY);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GET_B = 2'd1,
        EXEC  = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [LAT_W-1:0] cnt;

    logic accept_a;
    logic accept_b;
    logic capture;
    logic res_take;

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // -----------------------------------------------------------------------
    // Next state and handshake decode. Flush overrides every state and also
    // blocks the input handshake, so nothing is accepted in a flush cycle.
    // -----------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        accept_a  = 1'b0;
        accept_b  = 1'b0;
        capture   = 1'b0;
        res_take  = 1'b0;

        if (flush) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    in_ready = 1'b1;
                    if (in_valid) begin
                        accept_a  = 1'b1;
                        state_nxt = GET_B;
                    end
                end
                GET_B: begin
                    in_ready = 1'b1;
                    if (in_valid) begin
                        accept_b  = 1'b1;
                        state_nxt = EXEC;
                    end
                end
                EXEC: begin
                    if (cnt == '0) begin
                        capture   = 1'b1;
                        state_nxt = HOLD;
                    end
                end
                HOLD: begin
                    if (res_ready) begin
                        res_take  = 1'b1;
                        state_nxt = IDLE;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Operand registers. They move only on an accepted beat and survive flush.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            au_a   <= 8'h00;
            au_b   <= 8'h00;
            au_sel <= 2'b00;
        end else begin
            if (accept_a) begin
                au_a   <= in_data;
                au_sel <= in_op;
            end
            if (accept_b) begin
                au_b <= in_data;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Pipeline wait counter. Loaded with AU_LATENCY on the B beat so EXEC
    // spans AU_LATENCY+1 edges: the AU samples on the first, and the result
    // is captured on the edge where the counter has reached zero.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (flush) begin
            cnt <= '0;
        end else if (accept_b) begin
            cnt <= LAT_LOAD;
        end else if ((state == EXEC) && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    // -----------------------------------------------------------------------
    // Result capture and output handshake
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_data  <= 8'h00;
            res_op    <= 2'b00;
            res_valid <= 1'b0;
        end else if (flush) begin
            res_valid <= 1'b0;
        end else if (capture) begin
            res_data  <= au_out;
            res_op    <= au_sel;
            res_valid <= 1'b1;
        end else if (res_take) begin
            res_valid <= 1'b0;
        end
    end

    // Only results actually taken downstream are counted; a flushed result is not.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_count <= '0;
        end else if (res_take) begin
            op_count <= op_count + 1'b1;
        end
    end

    assign res_neg  = res_data[7];
    assign res_zero = (res_data == 8'h00);
    assign busy     = (state != IDLE);

endmodule

// File: tb/tb_au_operand_sequencer.sv
module tb_au_operand_sequencer;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       in_data;
    logic [1:0]       in_op;
    logic [7:0]       au_a;
    logic [7:0]       au_b;
    logic [1:0]       au_sel;
    logic [7:0]       au_out;
    logic             res_valid;
    logic             res_ready;
    logic [7:0]       res_data;
    logic [1:0]       res_op;
    logic             res_neg;
    logic             res_zero;
    logic             busy;
    logic [CNT_W-1:0] op_count;

    always #5 clk = ~clk;

    au_operand_sequencer #(
        .AU_LATENCY (1),
        .CNT_W      (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_op     (in_op),
        .au_a      (au_a),
        .au_b      (au_b),
        .au_sel    (au_sel),
        .au_out    (au_out),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_op    (res_op),
        .res_neg   (res_neg),
        .res_zero  (res_zero),
        .busy      (busy),
        .op_count  (op_count)
    );

    // AU stub: registers its inputs once, combinational add/sub behind them.
    logic [7:0] stub_a;
    logic [7:0] stub_b;
    logic [1:0] stub_sel;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stub_a   <= 8'h00;
            stub_b   <= 8'h00;
            stub_sel <= 2'b00;
        end else begin
            stub_a   <= au_a;
            stub_b   <= au_b;
            stub_sel <= au_sel;
        end
    end
    assign au_out = (stub_sel == 2'b00) ? (stub_a + stub_b) : (stub_a - stub_b);

    typedef struct {
        logic [7:0] data;
        logic [1:0] op;
        logic       neg;
        logic       zero;
    } exp_t;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [1:0] op;
        logic [7:0] data;
        logic       neg;
        logic       zero;
    } vec_t;

    exp_t             sbq[$];
    int               n_cmp = 0;
    int               n_err = 0;
    logic [CNT_W-1:0] exp_cnt = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: timed out", name);
    endtask

    function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op);
        exp_t e;
        e.data = (op == 2'b00) ? (a + b) : (a - b);
        e.op   = op;
        e.neg  = e.data[7];
        e.zero = (e.data == 8'h00);
        return e;
    endfunction

    task automatic send_beat(input logic [7:0] d, input logic [1:0] op);
        bit done;
        done     = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        in_op    = op;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            done = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!done) timeout_fail("beat_accept");
    endtask

    task automatic idle_gap(input int max_gap);
        int g;
        g = $urandom_range(0, max_gap);
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        repeat (g) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op,
                         input bit push, input int max_gap);
        idle_gap(max_gap);
        send_beat(a, op);
        idle_gap(max_gap);
        send_beat(b, 2'($urandom));
        if (push) sbq.push_back(model(a, b, op));
    endtask

    task automatic wait_res();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            seen = res_valid;
        end
        @(posedge clk);
        #1;
        if (!seen) timeout_fail("res_valid_wait");
    endtask

    task automatic drain();
        bit empty;
        empty = 1'b0;
        for (int i = 0; i < 200 && !empty; i++) begin
            if (sbq.size() == 0) empty = 1'b1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        if (!empty) timeout_fail("scoreboard_drain");
    endtask

    vec_t vecs[6];

    initial begin
        vecs[0] = '{a: 8'h05, b: 8'h03, op: 2'b00, data: 8'h08, neg: 1'b0, zero: 1'b0};
        vecs[1] = '{a: 8'h03, b: 8'h05, op: 2'b01, data: 8'hFE, neg: 1'b1, zero: 1'b0};
        vecs[2] = '{a: 8'h80, b: 8'h80, op: 2'b10, data: 8'h00, neg: 1'b0, zero: 1'b1};
        vecs[3] = '{a: 8'h7F, b: 8'h01, op: 2'b00, data: 8'h80, neg: 1'b1, zero: 1'b0};
        vecs[4] = '{a: 8'hFF, b: 8'h01, op: 2'b00, data: 8'h00, neg: 1'b0, zero: 1'b1};
        vecs[5] = '{a: 8'h10, b: 8'h20, op: 2'b11, data: 8'hF0, neg: 1'b1, zero: 1'b0};

        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        in_op     = 2'b00;
        res_ready = 1'b0;

        // Scoreboard monitor: compares each result at its accepting handshake.
        fork
            forever begin
                @(negedge clk);
                if (rst_n && res_valid && res_ready && !flush) begin
                    if (sbq.size() == 0) begin
                        timeout_fail("unexpected_result");
                    end else begin
                        exp_t e;
                        e = sbq.pop_front();
                        check("res_data", res_data, e.data);
                        check("res_op", res_op, e.op);
                        check("res_neg", res_neg, e.neg);
                        check("res_zero", res_zero, e.zero);
                        check("op_count_at_take", op_count, exp_cnt);
                    end
                    exp_cnt = exp_cnt + 1'b1;
                end
            end
        join_none

        // Reset values
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_res_valid", res_valid, 0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("post_rst_in_ready", in_ready, 1);
        check("post_rst_op_count", op_count, 0);

        // Single add with exact latency
        res_ready = 1'b1;
        send_beat(8'h05, 2'b00);
        check("getb_busy", busy, 1);
        send_beat(8'h03, 2'b00);
        sbq.push_back(model(8'h05, 8'h03, 2'b00));
        check("lat_e0_valid", res_valid, 0);
        check("exec_in_ready", in_ready, 0);
        @(posedge clk); #1;
        check("lat_e1_valid", res_valid, 0);
        @(posedge clk); #1;
        check("lat_e2_valid", res_valid, 1);
        check("lat_e2_data", res_data, 8'h08);
        @(posedge clk); #1;
        check("add_op_count", op_count, 1);
        check("add_res_valid_clr", res_valid, 0);

        // Table-driven ops, expectations taken from the table constants
        foreach (vecs[i]) begin
            exp_t e;
            send_beat(vecs[i].a, vecs[i].op);
            send_beat(vecs[i].b, 2'b11);
            e.data = vecs[i].data;
            e.op   = vecs[i].op;
            e.neg  = vecs[i].neg;
            e.zero = vecs[i].zero;
            sbq.push_back(e);
        end
        drain();

        // Backpressure: result held, new beat ignored
        res_ready = 1'b0;
        do_op(8'h40, 8'h11, 2'b00, 1'b1, 0);
        wait_res();
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_data  = 8'hAA;
            in_op    = 2'b11;
            @(negedge clk);
            check("bp_in_ready", in_ready, 0);
            check("bp_res_valid", res_valid, 1);
            check("bp_res_data", res_data, 8'h51);
            check("bp_res_op", res_op, 2'b00);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check("bp_au_a_kept", au_a, 8'h40);
        check("bp_au_sel_kept", au_sel, 2'b00);
        res_ready = 1'b1;
        do_op(8'h22, 8'h23, 2'b01, 1'b1, 1);
        drain();

        // Flush in GET_B: same-cycle beat refused
        send_beat(8'h11, 2'b00);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h99;
        @(negedge clk);
        check("flush_in_ready", in_ready, 0);
        @(posedge clk); #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush_getb_busy", busy, 0);
        check("flush_getb_valid", res_valid, 0);
        check("flush_getb_au_a", au_a, 8'h11);

        // Flush in HOLD with res_ready high: result dropped, count unchanged
        res_ready = 1'b0;
        do_op(8'h01, 8'h02, 2'b00, 1'b0, 0);
        wait_res();
        flush     = 1'b1;
        res_ready = 1'b1;
        @(posedge clk); #1;
        flush     = 1'b0;
        res_ready = 1'b0;
        check("flush_hold_valid", res_valid, 0);
        check("flush_hold_busy", busy, 0);
        check("flush_hold_count", op_count, exp_cnt);
        check("flush_hold_data_kept", res_data, 8'h03);
        res_ready = 1'b1;
        do_op(8'h7F, 8'h01, 2'b00, 1'b1, 0);
        drain();

        // Async reset mid-EXEC
        send_beat(8'h33, 2'b10);
        send_beat(8'h44, 2'b00);
        rst_n = 1'b0;
        #1;
        check("mid_rst_au_a", au_a, 0);
        check("mid_rst_au_b", au_b, 0);
        check("mid_rst_au_sel", au_sel, 0);
        check("mid_rst_res_data", res_data, 0);
        check("mid_rst_res_valid", res_valid, 0);
        check("mid_rst_op_count", op_count, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_in_ready", in_ready, 1);
        exp_cnt = '0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("mid_rst_no_result", res_valid, 0);

        // Counter wrap with randomly gapped beats
        for (int i = 0; i < 17; i++) begin
            do_op(8'($urandom), 8'($urandom), 2'($urandom), 1'b1, 3);
        end
        drain();
        check("wrap_op_count", op_count, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, %0d compared so far", n_cmp);
        $fatal(1, "global timeout");
    end

endmodule
